lcd_bus_arbiter: RTL and testbench

Shares the single HD44780-compatible character-LCD bus between two requesters: the init/CGRAM loader (port 0) and the text refresh engine (port 1). It accepts one 9-bit write word (RS + 8-bit data) per valid/ready handshake and generates the LCD_EN pulse sequence from a slow tick. It stretches the cycle for the clear and home commands. It sits between the display-content logic and the LCD pins, and replaces the ad-hoc DROP_LCD_E/HOLD sequencing inside the display top level.

---
 rtl/lcd_pkg.sv | 35 +++
 rtl/lcd_tick_gen.sv | 37 +++
 rtl/lcd_bus_arbiter.sv | 167 ++++++++++++++++
 tb/tb_lcd_bus_arbiter.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_pkg.sv
`default_nettype none
// ============================================================================
// Module   : lcd_pkg
// Purpose  : Shared definitions for the character-LCD bus arbiter: FSM state
//            encoding, HD44780 command constants, requester count and the
//            long-command classifier.
// Revision : 1.0 - initial release
// ============================================================================
package lcd_pkg;

    localparam int NUM_REQ = 2;

    localparam logic [7:0] LCD_CMD_CLEAR = 8'h01;
    localparam logic [7:0] LCD_CMD_HOME  = 8'h02;
    localparam logic [7:0] LCD_CMD_LINE1 = 8'h80;
    localparam logic [7:0] LCD_CMD_LINE2 = 8'hC0;
    localparam logic [7:0] LCD_CMD_CGRAM = 8'h40;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_SETUP     = 3'd1,
        ST_EN_HI     = 3'd2,
        ST_EN_LO     = 3'd3,
        ST_WAIT_LONG = 3'd4
    } lcd_state_t;

    // Clear (01), home (02) and its don't-care alias (03) need far longer
    // than a normal write for the controller to finish.
    function automatic logic is_long_cmd(input logic rs, input logic [7:0] data);
        return !rs && ((data == LCD_CMD_CLEAR) || (data == LCD_CMD_HOME) ||
                       (data == 8'h03));
    endfunction

endpackage : lcd_pkg
`default_nettype wire

// File: rtl/lcd_tick_gen.sv
`default_nettype none
// ============================================================================
// Module   : lcd_tick_gen
// Purpose  : Free-running prescaler producing a one-Clk tick every TICK_DIV
//            Clk cycles; paces the LCD enable sequence.
// Ports    : Clk  - system clock
//            rst  - asynchronous active-low reset
//            tick - one-cycle pulse while the prescaler is at TICK_DIV-1
// Revision : 1.0 - initial release
// ============================================================================
module lcd_tick_gen #(
    parameter int TICK_DIV = 62500
) (
    input  logic Clk,
    input  logic rst,
    output logic tick
);

    localparam int             CW     = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0]  c_last = CW'(TICK_DIV - 1);

    logic [CW-1:0] r_presc;

    always_ff @(posedge Clk or negedge rst) begin
        if (!rst) begin
            r_presc <= '0;
        end else if (r_presc == c_last) begin
            r_presc <= '0;
        end else begin
            r_presc <= r_presc + 1'b1;
        end
    end

    assign tick = (r_presc == c_last);

endmodule : lcd_tick_gen
`default_nettype wire

// File: rtl/lcd_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : lcd_bus_arbiter
// Purpose  : Shares one HD44780 write-only bus between the init/CGRAM loader
//            (port 0) and the text refresh engine (port 1). One RS+byte word
//            per valid/ready handshake; EN pulse paced by a slow tick, with
//            extra wait ticks after clear/home.
// Ports    : Clk, rst (async active-low)
//            req_valid/req_rs/req_lock [1:0], req_data [15:0] = {p1, p0}
//            req_ready [1:0] - one-Clk accept strobe
//            grant, busy     - owning port, transfer in progress
//            LCD_DATA (always driven), LCD_EN, LCD_RW (tied 0), LCD_RS
// Config   : LCD_ARB_RR_EN - round-robin arbitration instead of fixed
//            priority (port 0 over port 1).
// Revision : 1.0 - initial release
// ============================================================================
module lcd_bus_arbiter
    import lcd_pkg::*;
#(
    parameter int TICK_DIV   = 62500,
    parameter int LONG_TICKS = 2
) (
    input  logic                   Clk,
    input  logic                   rst,
    input  logic [NUM_REQ-1:0]     req_valid,
    input  logic [NUM_REQ-1:0]     req_rs,
    input  logic [NUM_REQ*8-1:0]   req_data,
    input  logic [NUM_REQ-1:0]     req_lock,
    output logic [NUM_REQ-1:0]     req_ready,
    output logic                   grant,
    output logic                   busy,
    inout  wire  [7:0]             LCD_DATA,
    output logic                   LCD_EN,
    output logic                   LCD_RW,
    output logic                   LCD_RS
);

    localparam int            LW          = (LONG_TICKS > 1) ? $clog2(LONG_TICKS) : 1;
    localparam logic [LW-1:0] c_lcnt_last = LW'(LONG_TICKS - 1);

    lcd_state_t       r_state;
    logic [1:0]       r_ready;
    logic             r_grant;
    logic             r_busy;
    logic             r_en;
    logic             r_rs;
    logic [7:0]       r_data;
    logic             r_long;
    logic [LW-1:0]    r_lcnt;

    logic             w_tick;
    logic [1:0]       w_elig;
    logic             w_win;
    logic             w_accept;
    logic             w_sel_rs;
    logic [7:0]       w_sel_data;

    lcd_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick (
        .Clk  (Clk),
        .rst  (rst),
        .tick (w_tick)
    );

    // A lock held by the current owner shuts out the other port, even while
    // the owner itself has nothing to send.
    assign w_elig[0] = req_valid[0] && !(req_lock[r_grant] && (r_grant == 1'b1));
    assign w_elig[1] = req_valid[1] && !(req_lock[r_grant] && (r_grant == 1'b0));

`ifdef LCD_ARB_RR_EN
    logic r_ptr;   // port granted last; the other one wins a tie

    assign w_win = (w_elig[0] && w_elig[1]) ? ~r_ptr : w_elig[1];

    always_ff @(posedge Clk or negedge rst) begin
        if (!rst) begin
            r_ptr <= 1'b1;
        end else if (w_accept) begin
            r_ptr <= w_win;
        end
    end
`else
    assign w_win = !w_elig[0];
`endif

    assign w_accept   = (r_state == ST_IDLE) && (w_elig != 2'b00);
    assign w_sel_rs   = req_rs[w_win];
    assign w_sel_data = w_win ? req_data[15:8] : req_data[7:0];

    always_ff @(posedge Clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_ready <= 2'b00;
            r_grant <= 1'b0;
            r_busy  <= 1'b0;
            r_en    <= 1'b0;
            r_rs    <= 1'b0;
            r_data  <= 8'h00;
            r_long  <= 1'b0;
            r_lcnt  <= '0;
        end else begin
            r_ready <= 2'b00;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_ready <= w_win ? 2'b10 : 2'b01;
                        r_grant <= w_win;
                        r_rs    <= w_sel_rs;
                        r_data  <= w_sel_data;
                        r_long  <= is_long_cmd(w_sel_rs, w_sel_data);
                        r_busy  <= 1'b1;
                        r_state <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    if (w_tick) begin
                        r_en    <= 1'b1;
                        r_state <= ST_EN_HI;
                    end
                end
                ST_EN_HI: begin
                    if (w_tick) begin
                        r_en    <= 1'b0;
                        r_state <= ST_EN_LO;
                    end
                end
                ST_EN_LO: begin
                    if (w_tick) begin
                        if (r_long) begin
                            r_lcnt  <= '0;
                            r_state <= ST_WAIT_LONG;
                        end else begin
                            r_busy  <= 1'b0;
                            r_state <= ST_IDLE;
                        end
                    end
                end
                ST_WAIT_LONG: begin
                    if (w_tick) begin
                        if (r_lcnt == c_lcnt_last) begin
                            r_busy  <= 1'b0;
                            r_state <= ST_IDLE;
                        end else begin
                            r_lcnt <= r_lcnt + 1'b1;
                        end
                    end
                end
                default: begin
                    r_en    <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign req_ready = r_ready;
    assign grant     = r_grant;
    assign busy      = r_busy;
    assign LCD_DATA  = r_data;
    assign LCD_EN    = r_en;
    assign LCD_RW    = 1'b0;
    assign LCD_RS    = r_rs;

endmodule : lcd_bus_arbiter
`default_nettype wire

// File: tb/tb_lcd_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_lcd_bus_arbiter
// Purpose  : Directed, table-driven bench for lcd_bus_arbiter with
//            TICK_DIV=4, LONG_TICKS=2.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lcd_bus_arbiter;

    localparam int TD = 4;
    localparam int LT = 2;

    logic        Clk = 1'b0;
    logic        rst = 1'b0;
    logic [1:0]  req_valid = 2'b00;
    logic [1:0]  req_rs    = 2'b00;
    logic [15:0] req_data  = 16'h0000;
    logic [1:0]  req_lock  = 2'b00;
    logic [1:0]  req_ready;
    logic        grant;
    logic        busy;
    wire  [7:0]  lcd_data;
    logic        LCD_EN;
    logic        LCD_RW;
    logic        LCD_RS;

    int checks = 0;
    int errors = 0;
    int m_presc;   // reference prescaler: free-running 0..TD-1 from reset

    lcd_bus_arbiter #(
        .TICK_DIV   (TD),
        .LONG_TICKS (LT)
    ) dut (
        .Clk       (Clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_rs    (req_rs),
        .req_data  (req_data),
        .req_lock  (req_lock),
        .req_ready (req_ready),
        .grant     (grant),
        .busy      (busy),
        .LCD_DATA  (lcd_data),
        .LCD_EN    (LCD_EN),
        .LCD_RW    (LCD_RW),
        .LCD_RS    (LCD_RS)
    );

    always #5 Clk = ~Clk;

    always @(posedge Clk or negedge rst) begin
        if (!rst) m_presc <= 0;
        else      m_presc <= (m_presc == TD - 1) ? 0 : m_presc + 1;
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // One complete transfer on port p, checked from accept to busy falling.
    task automatic xfer(input int p, input logic rs, input logic [7:0] d,
                        input logic lk, input logic exp_long, input string nm);
        int  n;
        int  k;
        int  busy_n;
        int  en_n;
        int  extra_rdy;
        bit  stable;
        bit  got;
        int  exp_busy;
        req_rs[p]          = rs;
        req_data[p*8 +: 8] = d;
        req_lock[p]        = lk;
        req_valid[p]       = 1'b1;
        got = 0;
        n   = 0;
        while (!got && n < 60) begin
            @(posedge Clk); #1;
            if (req_ready != 2'b00) got = 1;
            n++;
        end
        check({nm, " accept"}, 32'(got), 32'd1);
        if (got) begin
            k = m_presc;
            req_valid[p] = 1'b0;
            check({nm, " ready_onehot"}, 32'(req_ready), 32'(2'b01 << p));
            check({nm, " grant"}, 32'(grant), 32'(p));
            check({nm, " data"}, 32'(lcd_data), 32'(d));
            check({nm, " rs"}, 32'(LCD_RS), 32'(rs));
            check({nm, " rw"}, 32'(LCD_RW), 32'd0);
            busy_n = 0; en_n = 0; extra_rdy = 0; stable = 1;
            while (busy && busy_n < 200) begin
                if (busy_n != 0 && req_ready != 2'b00) extra_rdy++;
                if (LCD_EN) en_n++;
                if (lcd_data !== d || LCD_RS !== rs || grant !== p[0]) stable = 0;
                busy_n++;
                @(posedge Clk); #1;
            end
            exp_busy = (TD - k) + 2 * TD + (exp_long ? LT * TD : 0);
            check({nm, " busy_len"}, 32'(busy_n), 32'(exp_busy));
            check({nm, " en_len"}, 32'(en_n), 32'(TD));
            check({nm, " stable"}, 32'(stable), 32'd1);
            check({nm, " single_ready"}, 32'(extra_rdy), 32'd0);
            check({nm, " en_low_end"}, 32'(LCD_EN), 32'd0);
        end else begin
            req_valid[p] = 1'b0;
        end
    endtask

    typedef struct {
        int         port;
        logic       rs;
        logic [7:0] data;
        logic       exp_long;
    } vec_t;

    vec_t vecs[8];
    int   exp_ord[4];

    initial begin
        vecs[0] = '{port: 1, rs: 1'b1, data: 8'h41, exp_long: 1'b0};
        vecs[1] = '{port: 0, rs: 1'b0, data: 8'h01, exp_long: 1'b1};
        vecs[2] = '{port: 0, rs: 1'b0, data: 8'h06, exp_long: 1'b0};
        vecs[3] = '{port: 0, rs: 1'b1, data: 8'h01, exp_long: 1'b0};
        vecs[4] = '{port: 1, rs: 1'b0, data: 8'h02, exp_long: 1'b1};
        vecs[5] = '{port: 0, rs: 1'b0, data: 8'h03, exp_long: 1'b1};
        vecs[6] = '{port: 0, rs: 1'b0, data: 8'h80, exp_long: 1'b0};
        vecs[7] = '{port: 1, rs: 1'b0, data: 8'hC0, exp_long: 1'b0};
`ifdef LCD_ARB_RR_EN
        exp_ord = '{0, 1, 0, 1};
`else
        exp_ord = '{0, 0, 0, 0};
`endif

        // ---- reset values with port 0 already requesting ----
        req_valid[0]   = 1'b1;
        req_rs[0]      = 1'b0;
        req_data[7:0]  = 8'h38;
        repeat (3) @(negedge Clk);
        check("rst LCD_EN", 32'(LCD_EN), 32'd0);
        check("rst LCD_RW", 32'(LCD_RW), 32'd0);
        check("rst LCD_RS", 32'(LCD_RS), 32'd0);
        check("rst LCD_DATA", 32'(lcd_data), 32'h00);
        check("rst req_ready", 32'(req_ready), 32'd0);
        check("rst busy", 32'(busy), 32'd0);
        check("rst grant", 32'(grant), 32'd0);
        rst = 1'b1;
        xfer(0, 1'b0, 8'h38, 1'b0, 1'b0, "first_38");

        // ---- table of single transfers ----
        for (int i = 0; i < 8; i++) begin
            xfer(vecs[i].port, vecs[i].rs, vecs[i].data, 1'b0, vecs[i].exp_long,
                 $sformatf("vec%0d", i));
        end

        // ---- both ports valid continuously for four transfers ----
        req_rs = 2'b11;
        req_data = {8'hB0, 8'hA0};
        req_valid = 2'b11;
        for (int t = 0; t < 4; t++) begin
            int  n;
            bit  got;
            int  w;
            got = 0; n = 0;
            while (!got && n < 60) begin
                @(posedge Clk); #1;
                if (req_ready != 2'b00) got = 1;
                n++;
            end
            check($sformatf("arb%0d accept", t), 32'(got), 32'd1);
            w = req_ready[1] ? 1 : 0;
            check($sformatf("arb%0d onehot", t), 32'(req_ready[0] ^ req_ready[1]), 32'd1);
            check($sformatf("arb%0d order", t), 32'(w), 32'(exp_ord[t]));
            n = 0;
            while (busy && n < 100) begin
                @(posedge Clk); #1;
                n++;
            end
            check($sformatf("arb%0d busy_end", t), 32'(busy), 32'd0);
        end
        req_valid = 2'b00;

        // ---- lock: CGRAM address then 8 bytes while port 1 waits ----
        req_rs[1]      = 1'b1;
        req_data[15:8] = 8'h55;
        req_valid[1]   = 1'b1;
        xfer(0, 1'b0, 8'h40, 1'b1, 1'b0, "lock_cgram");
        for (int b = 0; b < 8; b++) begin
            xfer(0, 1'b1, 8'(8'h10 + b), 1'b1, 1'b0, $sformatf("lock_byte%0d", b));
        end
        begin
            int idle_rdy;
            idle_rdy = 0;
            for (int c = 0; c < 10; c++) begin
                @(posedge Clk); #1;
                if (req_ready != 2'b00 || busy) idle_rdy++;
            end
            check("lock_hold no_grant", 32'(idle_rdy), 32'd0);
        end
        req_lock[0] = 1'b0;
        xfer(1, 1'b1, 8'h55, 1'b0, 1'b0, "after_unlock");

        // ---- reset while EN is high ----
        req_valid[0]  = 1'b1;
        req_rs[0]     = 1'b0;
        req_data[7:0] = 8'h06;
        begin
            int n;
            n = 0;
            while (req_ready[0] !== 1'b1 && n < 60) begin
                @(posedge Clk); #1;
                n++;
            end
            req_valid[0] = 1'b0;
            n = 0;
            while (LCD_EN !== 1'b1 && n < 60) begin
                @(posedge Clk); #1;
                n++;
            end
            check("midrst en_seen", 32'(LCD_EN), 32'd1);
            #2 rst = 1'b0;
            #1;
            check("midrst en_async", 32'(LCD_EN), 32'd0);
            check("midrst busy", 32'(busy), 32'd0);
            @(negedge Clk);
            rst = 1'b1;
            n = 0;
            for (int c = 0; c < 6; c++) begin
                @(posedge Clk); #1;
                if (busy || LCD_EN || req_ready != 2'b00) n++;
            end
            check("midrst idle_after", 32'(n), 32'd0);
        end
        xfer(1, 1'b1, 8'h5A, 1'b0, 1'b0, "post_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule : tb_lcd_bus_arbiter
`default_nettype wire
